reg_file_mp: RTL and testbench

REG_FILE_MP -- requirements
Module: reg_file_mp

---
 rtl/reg_file_mp.sv | 121 ++++++++++++
 tb/tb_reg_file_mp.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/reg_file_mp.sv
// Multi-port register file: ALU write port, PC write port, two registered read ports,
// masked status flags and per-register pending-load locks. Optional debug port: REG_FILE_MP_DEBUG_EN.
module reg_file_mp #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4,
    parameter int PC_IDX = 15,
    parameter int FLAG_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] rd_a_sel,
    input  logic [ADDR_W-1:0] rd_b_sel,
    input  logic              rd_b_en,
    input  logic [ADDR_W-1:0] wr_sel,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              pc_wr_en,
    input  logic [DATA_W-1:0] pc_wr_data,
    input  logic [FLAG_W-1:0] flag_wr_mask,
    input  logic [FLAG_W-1:0] flag_wr_data,
    input  logic              lock_en,
    input  logic [ADDR_W-1:0] lock_sel,
    output logic [DATA_W-1:0] rd_a_data,
    output logic [DATA_W-1:0] rd_b_data,
    output logic [DATA_W-1:0] pc_data,
    output logic [FLAG_W-1:0] flags,
    output logic              rd_a_busy,
    output logic              rd_b_busy
`ifdef REG_FILE_MP_DEBUG_EN
    ,
    input  logic [ADDR_W-1:0] dbg_sel,
    output logic [DATA_W-1:0] dbg_data
`endif
);

    localparam int NREG = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] PC_SEL = PC_IDX[ADDR_W-1:0];

    logic [DATA_W-1:0] regs_q [NREG];
    logic [DATA_W-1:0] regs_d [NREG];
    logic [NREG-1:0]   lock_q, lock_d;
    logic [FLAG_W-1:0] flags_q, flags_d;
    logic [DATA_W-1:0] rd_a_q, rd_a_d;
    logic [DATA_W-1:0] rd_b_q, rd_b_d;
    logic              rd_b_oe_q, rd_b_oe_d;
    logic [DATA_W-1:0] pc_q, pc_d;
    logic              rd_a_busy_q, rd_a_busy_d;
    logic              rd_b_busy_q, rd_b_busy_d;
    logic              pc_wr_ok;
`ifdef REG_FILE_MP_DEBUG_EN
    logic [DATA_W-1:0] dbg_q, dbg_d;
`endif

    always_comb begin
        // ALU write to the PC slot overrides the incrementer
        pc_wr_ok = pc_wr_en && !(wr_en && (wr_sel == PC_SEL));

        regs_d = regs_q;
        if (pc_wr_ok) regs_d[PC_SEL] = pc_wr_data;
        if (wr_en)    regs_d[wr_sel] = wr_data;

        lock_d = lock_q;
        if (wr_en)    lock_d[wr_sel]   = 1'b0;
        if (pc_wr_ok) lock_d[PC_SEL]   = 1'b0;
        if (lock_en)  lock_d[lock_sel] = 1'b1;

        flags_d = (flags_q & ~flag_wr_mask) | (flag_wr_data & flag_wr_mask);

        rd_a_d      = regs_d[rd_a_sel];
        pc_d        = regs_d[PC_SEL];
        rd_a_busy_d = lock_d[rd_a_sel];
        rd_b_oe_d   = rd_b_en;
        rd_b_d      = rd_b_en ? regs_d[rd_b_sel] : rd_b_q;
        rd_b_busy_d = rd_b_en ? lock_d[rd_b_sel] : 1'b0;
`ifdef REG_FILE_MP_DEBUG_EN
        dbg_d = regs_d[dbg_sel];
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
            lock_q      <= '0;
            flags_q     <= '0;
            rd_a_q      <= '0;
            rd_b_q      <= '0;
            // read B is driven (as zero) right after reset regardless of rd_b_en
            rd_b_oe_q   <= 1'b1;
            pc_q        <= '0;
            rd_a_busy_q <= 1'b0;
            rd_b_busy_q <= 1'b0;
`ifdef REG_FILE_MP_DEBUG_EN
            dbg_q       <= '0;
`endif
        end else begin
            regs_q      <= regs_d;
            lock_q      <= lock_d;
            flags_q     <= flags_d;
            rd_a_q      <= rd_a_d;
            rd_b_q      <= rd_b_d;
            rd_b_oe_q   <= rd_b_oe_d;
            pc_q        <= pc_d;
            rd_a_busy_q <= rd_a_busy_d;
            rd_b_busy_q <= rd_b_busy_d;
`ifdef REG_FILE_MP_DEBUG_EN
            dbg_q       <= dbg_d;
`endif
        end
    end

    assign rd_a_data = rd_a_q;
    assign rd_b_data = rd_b_oe_q ? rd_b_q : {DATA_W{1'bz}};
    assign pc_data   = pc_q;
    assign flags     = flags_q;
    assign rd_a_busy = rd_a_busy_q;
    assign rd_b_busy = rd_b_busy_q;
`ifdef REG_FILE_MP_DEBUG_EN
    assign dbg_data  = dbg_q;
`endif

endmodule

// File: tb/tb_reg_file_mp.sv
// Self-checking bench for reg_file_mp: table of stimulus/expected vectors plus a
// write-all/read-all sequence, with expected results passed through a scoreboard queue.
module tb_reg_file_mp;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  rd_a_sel, rd_b_sel, wr_sel, lock_sel;
    logic        rd_b_en, wr_en, pc_wr_en, lock_en;
    logic [31:0] wr_data, pc_wr_data;
    logic [3:0]  flag_wr_mask, flag_wr_data;
    logic [31:0] rd_a_data, rd_b_data, pc_data;
    logic [3:0]  flags;
    logic        rd_a_busy, rd_b_busy;
`ifdef REG_FILE_MP_DEBUG_EN
    logic [3:0]  dbg_sel = 4'd0;
    logic [31:0] dbg_data;
`endif

    always #5 clk = ~clk;

    reg_file_mp dut (
        .clk(clk), .reset(reset),
        .rd_a_sel(rd_a_sel), .rd_b_sel(rd_b_sel), .rd_b_en(rd_b_en),
        .wr_sel(wr_sel), .wr_en(wr_en), .wr_data(wr_data),
        .pc_wr_en(pc_wr_en), .pc_wr_data(pc_wr_data),
        .flag_wr_mask(flag_wr_mask), .flag_wr_data(flag_wr_data),
        .lock_en(lock_en), .lock_sel(lock_sel),
        .rd_a_data(rd_a_data), .rd_b_data(rd_b_data), .pc_data(pc_data),
        .flags(flags), .rd_a_busy(rd_a_busy), .rd_b_busy(rd_b_busy)
`ifdef REG_FILE_MP_DEBUG_EN
        , .dbg_sel(dbg_sel), .dbg_data(dbg_data)
`endif
    );

    typedef struct {
        logic        rst;
        logic        we;
        logic [3:0]  ws;
        logic [31:0] wd;
        logic        pwe;
        logic [31:0] pwd;
        logic [3:0]  ra;
        logic [3:0]  rb;
        logic        rbe;
        logic        le;
        logic [3:0]  ls;
        logic [3:0]  fm;
        logic [3:0]  fd;
        logic [31:0] ea;
        logic [31:0] eb;
        logic [31:0] epc;
        logic [3:0]  ef;
        logic        eab;
        logic        ebb;
    } vec_t;

    typedef struct {
        logic [31:0] ea;
        logic [31:0] eb;
        logic [31:0] epc;
        logic [3:0]  ef;
        logic        eab;
        logic        ebb;
    } exp_t;

    vec_t vecs[18];
    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    logic [31:0] model [16];

    function automatic vec_t mk(
        input logic rst, input logic we, input logic [3:0] ws, input logic [31:0] wd,
        input logic pwe, input logic [31:0] pwd,
        input logic [3:0] ra, input logic [3:0] rb, input logic rbe,
        input logic le, input logic [3:0] ls, input logic [3:0] fm, input logic [3:0] fd,
        input logic [31:0] ea, input logic [31:0] eb, input logic ebz,
        input logic [31:0] epc, input logic [3:0] ef, input logic eab, input logic ebb);
        vec_t v;
        v.rst = rst; v.we = we; v.ws = ws; v.wd = wd; v.pwe = pwe; v.pwd = pwd;
        v.ra = ra; v.rb = rb; v.rbe = rbe; v.le = le; v.ls = ls; v.fm = fm; v.fd = fd;
        v.ea = ea; v.eb = ebz ? 32'bz : eb; v.epc = epc; v.ef = ef; v.eab = eab; v.ebb = ebb;
        return v;
    endfunction

    task automatic cmp(input string tag, input string field, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s.%s: got %h, expected %h", tag, field, act, exp);
        end
    endtask

    task automatic drive_and_check(input vec_t v, input string tag);
        exp_t e;
        @(negedge clk);
        reset = v.rst; wr_en = v.we; wr_sel = v.ws; wr_data = v.wd;
        pc_wr_en = v.pwe; pc_wr_data = v.pwd;
        rd_a_sel = v.ra; rd_b_sel = v.rb; rd_b_en = v.rbe;
        lock_en = v.le; lock_sel = v.ls;
        flag_wr_mask = v.fm; flag_wr_data = v.fd;
        e.ea = v.ea; e.eb = v.eb; e.epc = v.epc; e.ef = v.ef; e.eab = v.eab; e.ebb = v.ebb;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        cmp(tag, "rd_a_data", rd_a_data, e.ea);
        cmp(tag, "rd_b_data", rd_b_data, e.eb);
        cmp(tag, "pc_data",   pc_data,   e.epc);
        cmp(tag, "flags",     {28'd0, flags},     {28'd0, e.ef});
        cmp(tag, "rd_a_busy", {31'd0, rd_a_busy}, {31'd0, e.eab});
        cmp(tag, "rd_b_busy", {31'd0, rd_b_busy}, {31'd0, e.ebb});
    endtask

    initial begin
        vec_t v;
        reset = 1'b1; wr_en = 0; wr_sel = 0; wr_data = 0; pc_wr_en = 0; pc_wr_data = 0;
        rd_a_sel = 0; rd_b_sel = 0; rd_b_en = 0; lock_en = 0; lock_sel = 0;
        flag_wr_mask = 0; flag_wr_data = 0;

        //             rst we ws  wd            pwe pwd        ra  rb  rbe le ls  fm       fd        ea            eb            ebz epc        ef       eab ebb
        vecs[0]  = mk(1, 0, 0,  32'h0,        0, 32'h0,      3,  0,  0,  0, 0,  4'b0000, 4'b0000,  32'h0,        32'h0,        0,  32'h0,     4'b0000, 0, 0);
        vecs[1]  = mk(0, 1, 5,  32'hDEADBEEF, 0, 32'h0,      5,  5,  1,  0, 0,  4'b0000, 4'b0000,  32'hDEADBEEF, 32'hDEADBEEF, 0,  32'h0,     4'b0000, 0, 0);
        vecs[2]  = mk(0, 1, 15, 32'h100,      1, 32'h204,    15, 5,  1,  0, 0,  4'b0000, 4'b0000,  32'h100,      32'hDEADBEEF, 0,  32'h100,   4'b0000, 0, 0);
        vecs[3]  = mk(0, 1, 2,  32'h7,        1, 32'h8,      2,  15, 1,  0, 0,  4'b0000, 4'b0000,  32'h7,        32'h8,        0,  32'h8,     4'b0000, 0, 0);
        vecs[4]  = mk(0, 0, 0,  32'h0,        0, 32'h0,      5,  2,  1,  0, 0,  4'b0101, 4'b1111,  32'hDEADBEEF, 32'h7,        0,  32'h8,     4'b0101, 0, 0);
        vecs[5]  = mk(0, 0, 0,  32'h0,        0, 32'h0,      0,  0,  0,  0, 0,  4'b1001, 4'b1000,  32'h0,        32'h0,        1,  32'h8,     4'b1100, 0, 0);
        vecs[6]  = mk(0, 0, 0,  32'h0,        0, 32'h0,      4,  4,  1,  1, 4,  4'b0000, 4'b0000,  32'h0,        32'h0,        0,  32'h8,     4'b1100, 1, 1);
        vecs[7]  = mk(0, 0, 0,  32'h0,        0, 32'h0,      4,  4,  1,  0, 0,  4'b0000, 4'b0000,  32'h0,        32'h0,        0,  32'h8,     4'b1100, 1, 1);
        vecs[8]  = mk(0, 1, 4,  32'h55,       0, 32'h0,      4,  4,  1,  0, 0,  4'b0000, 4'b0000,  32'h55,       32'h55,       0,  32'h8,     4'b1100, 0, 0);
        vecs[9]  = mk(0, 0, 0,  32'h0,        0, 32'h0,      4,  4,  0,  0, 0,  4'b0000, 4'b0000,  32'h55,       32'h0,        1,  32'h8,     4'b1100, 0, 0);
        vecs[10] = mk(0, 1, 7,  32'h77,       0, 32'h0,      7,  4,  0,  1, 7,  4'b0000, 4'b0000,  32'h77,       32'h0,        1,  32'h8,     4'b1100, 1, 0);
        vecs[11] = mk(0, 0, 0,  32'h0,        1, 32'h300,    15, 7,  1,  1, 15, 4'b0000, 4'b0000,  32'h300,      32'h77,       0,  32'h300,   4'b1100, 1, 1);
        vecs[12] = mk(0, 0, 0,  32'h0,        1, 32'h304,    15, 7,  1,  0, 0,  4'b0000, 4'b0000,  32'h304,      32'h77,       0,  32'h304,   4'b1100, 0, 1);
        vecs[13] = mk(0, 1, 15, 32'h500,      1, 32'h308,    5,  15, 1,  0, 0,  4'b0000, 4'b0000,  32'hDEADBEEF, 32'h500,      0,  32'h500,   4'b1100, 0, 0);
        vecs[14] = mk(0, 1, 7,  32'h99,       0, 32'h0,      7,  2,  1,  0, 0,  4'b0000, 4'b0000,  32'h99,       32'h7,        0,  32'h500,   4'b1100, 0, 0);
        vecs[15] = mk(1, 1, 3,  32'h33,       1, 32'h44,     3,  5,  0,  1, 3,  4'b1111, 4'b0011,  32'h0,        32'h0,        0,  32'h0,     4'b0000, 0, 0);
        vecs[16] = mk(0, 0, 0,  32'h0,        0, 32'h0,      3,  5,  1,  0, 0,  4'b0000, 4'b0000,  32'h0,        32'h0,        0,  32'h0,     4'b0000, 0, 0);
        vecs[17] = mk(0, 0, 0,  32'h0,        0, 32'h0,      7,  15, 1,  0, 0,  4'b0000, 4'b0000,  32'h0,        32'h0,        0,  32'h0,     4'b0000, 0, 0);

        for (int i = 0; i < 18; i++) drive_and_check(vecs[i], $sformatf("vec%0d", i));

        // write every register, then read them all back on both ports
        for (int i = 0; i < 16; i++) model[i] = 32'h0;
        for (int i = 0; i < 16; i++) begin
            model[i] = 32'hA500_0000 + 32'(i * 3 + 1);
            v = mk(0, 1, 4'(i), model[i], 0, 32'h0, 4'(i), 4'((i + 1) % 16), 1, 0, 0, 4'b0, 4'b0,
                   model[i], model[(i + 1) % 16], 0, model[15], 4'b0, 0, 0);
            drive_and_check(v, $sformatf("wr%0d", i));
        end
        for (int i = 0; i < 16; i++) begin
            v = mk(0, 0, 0, 32'h0, 0, 32'h0, 4'(i), 4'(15 - i), 1, 0, 0, 4'b0, 4'b0,
                   model[i], model[15 - i], 0, model[15], 4'b0, 0, 0);
            drive_and_check(v, $sformatf("rd%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
